// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner with press/release debounce.
// Accepted keys shift into a two-digit register for the display.
module keypad_scan_ctrl #(
  parameter int SCAN_COUNT     = 100_000,
  parameter int DEBOUNCE_COUNT = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_left,
  output logic [3:0] digit_right
);

  localparam int SW = $clog2(SCAN_COUNT);
  localparam int DW = $clog2(DEBOUNCE_COUNT);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_COUNT - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_COUNT - 1);

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HELD,
    RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] scan_q, scan_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic          valid_d;
  logic [3:0]    code_d, left_d, right_d;

  logic [3:0] rows_m, rows_s;
  logic [3:0] low;
  logic       one_low;
  logic [1:0] hit_row;
  logic       row_lo;

  function automatic logic [3:0] key_map(
    input logic [1:0] r,
    input logic [1:0] c
  );
    logic [3:0] k;
    case ({r, c})
      4'b00_00: k = 4'h1;
      4'b00_01: k = 4'h2;
      4'b00_10: k = 4'h3;
      4'b00_11: k = 4'hA;
      4'b01_00: k = 4'h4;
      4'b01_01: k = 4'h5;
      4'b01_10: k = 4'h6;
      4'b01_11: k = 4'hB;
      4'b10_00: k = 4'h7;
      4'b10_01: k = 4'h8;
      4'b10_10: k = 4'h9;
      4'b10_11: k = 4'hC;
      4'b11_00: k = 4'hE;
      4'b11_01: k = 4'h0;
      4'b11_10: k = 4'hF;
      default:  k = 4'hD;
    endcase
    return k;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      rows_m <= 4'b1111;
      rows_s <= 4'b1111;
    end else begin
      rows_m <= rows;
      rows_s <= rows_m;
    end
  end

  assign cols    = ~(4'b0001 << col_q);
  assign low     = ~rows_s;
  assign one_low = (low != 4'd0) &&
                   ((low & (low - 4'd1)) == 4'd0);
  assign row_lo  = low[row_q];

  always_comb begin
    hit_row = 2'd0;
    case (low)
      4'b0010: hit_row = 2'd1;
      4'b0100: hit_row = 2'd2;
      4'b1000: hit_row = 2'd3;
      default: hit_row = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    scan_d  = scan_q;
    deb_d   = deb_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    code_d  = key_code;
    left_d  = digit_left;
    right_d = digit_right;
    unique case (state_q)
      SCAN: begin
        if (scan_q == SCAN_LAST) begin
          scan_d = '0;
          if (one_low) begin
            state_d = DEBOUNCE;
            deb_d   = '0;
            row_d   = hit_row;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          scan_d = scan_q + SW'(1);
        end
      end
      DEBOUNCE: begin
        if (!row_lo) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          scan_d  = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = HELD;
          valid_d = 1'b1;
          code_d  = key_map(row_q, col_q);
          left_d  = digit_right;
          right_d = key_map(row_q, col_q);
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      HELD: begin
        if (!row_lo) begin
          state_d = RELEASE;
          deb_d   = '0;
        end
      end
      RELEASE: begin
        // a low blip here is release bounce, not a new press
        if (row_lo) begin
          state_d = HELD;
          deb_d   = '0;
        end else if (deb_q == DEB_LAST) begin
          state_d = SCAN;
          col_d   = col_q + 2'd1;
          scan_d  = '0;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      default: state_d = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCAN;
      scan_q      <= '0;
      deb_q       <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      key_valid   <= 1'b0;
      key_code    <= 4'h0;
      digit_left  <= 4'h0;
      digit_right <= 4'h0;
    end else begin
      state_q     <= state_d;
      scan_q      <= scan_d;
      deb_q       <= deb_d;
      col_q       <= col_d;
      row_q       <= row_d;
      key_valid   <= valid_d;
      key_code    <= code_d;
      digit_left  <= left_d;
      digit_right <= right_d;
    end
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Scans a 4x4 matrix keypad and debounces presses.
- Each new key press shifts into a two-digit register: the old right digit moves to the left position and the new key becomes the right digit.
- digit_left/digit_right feed the two-digit time-multiplexed seven-segment display driver as its sw1/sw2 operands.
- Guarantees exactly one registered key event per physical press.

Parameters:
- SCAN_COUNT, 100_000: cycles each column stays driven during scanning (>=2).
- DEBOUNCE_COUNT, 500_000: consecutive stable cycles needed to accept a press or a release (>=2).

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- rows, input, 4: keypad row lines, active-low (pulled up), asynchronous to clk.
- cols, output, 4: keypad column drive, active-low; exactly one bit low at all times.
- key_valid, output, 1: one-cycle pulse when a press is accepted.
- key_code, output, 4: hex code of the last accepted key; holds between presses.
- digit_left, output, 4: older digit, sent to the left display.
- digit_right, output, 4: newest digit, sent to the right display.

Behaviour:
- Synchronizer:
  - rows pass through a 2-flop synchronizer (rows_s), reset value 4'b1111.
  - A pin change is visible on rows_s 2 cycles later.
  - All decisions below use rows_s only.
- Reset (checked at the clk edge, overrides everything):
  - cols=4'b1110, key_valid=0, key_code=0, digit_left=0, digit_right=0.
  - state=SCAN, counters=0.
  - Asserting reset mid-press discards the press. Reset values appear the cycle after reset is sampled.
- Key map, (row,col) -> code, row index r = bit of rows, column index c = low bit of cols:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- SCAN state:
  - scan_cnt counts 0..SCAN_COUNT-1 with the current column driven.
  - At scan_cnt==SCAN_COUNT-1 (settle point), rows_s is evaluated:
    - exactly one bit low: latch row/col, go to DEBOUNCE; cols stay frozen; deb_cnt=0.
    - no bit low, or two or more bits low: rotate to the next column (1110->1101->1011->0111->1110); scan_cnt=0.
- DEBOUNCE state:
  - Latched row low: deb_cnt increments.
  - On the cycle deb_cnt reaches DEBOUNCE_COUNT-1 with the row still low: go to HELD and, in that same cycle's update:
    - key_valid=1 for one cycle;
    - key_code = mapped code;
    - digit_left <= digit_right;
    - digit_right <= code.
  - Latched row high at any point: abandon the press, go to SCAN, advance to the next column, scan_cnt=0; no event.
  - Other rows going low are ignored.
- HELD state:
  - cols stay frozen; no further events.
  - Latched row high: go to RELEASE with deb_cnt=0.
- RELEASE state:
  - Latched row high: deb_cnt increments. At DEBOUNCE_COUNT-1: go to SCAN, advance to the next column, scan_cnt=0.
  - Latched row low again (release bounce): return to HELD, deb_cnt=0; no new event.
- Output rules:
  - key_valid is never high on two consecutive cycles.
  - digit outputs change only on key_valid cycles.
  - Counter widths are sized by $clog2 of each parameter; no counter wraps unintentionally.

Test Plan:
All scenarios use SCAN_COUNT=4 and DEBOUNCE_COUNT=8.
1. Reset, no keys pressed -> cols=1110, digits=0/0, key_valid=0. Scanning cycles cols 1110->1101->1011->0111->1110, changing every 4 cycles.
2. Hold row1 low while col1 is driven, for 40 cycles -> exactly one key_valid pulse, key_code=5, digit_left=0, digit_right=5. cols held at 1101 until release; scanning resumes at 1011 after 8 stable-high cycles.
3. After scenario 2, press row0/col3 -> key_code=A, digit_left=5, digit_right=A.
4. Press bounce: row low 3 cycles then high -> no key_valid, digits unchanged, scan moves to the next column.
5. Rows 0 and 2 low together in the same column -> ignored, no event, scan continues. Release bounce: high 3 cycles, low 2, then high 8 -> exactly one pulse for the whole press.
6. reset asserted for 1 cycle during HELD -> the next cycle shows cols=1110, digits 0/0, state SCAN. Releasing the key afterwards produces no event.
